// File: rtl/ok_trigger_capture_bank.sv
// ok_trigger_capture_bank
//   Multi-channel trigger-out capture bank. Each channel watches one WIDTH-bit
//   trigger word and accumulates per-bit events (rise / fall / both / level,
//   chosen per channel). A one-cycle snap request moves every channel's
//   accumulator into a hold register for host readout. Events that hit an
//   already-set accumulator bit are counted per channel as lost events.
//
// Ports
//   ti_clk      in   clock
//   ti_reset    in   synchronous active-high reset
//   ep_trigger  in   NCHAN*WIDTH trigger inputs, channel c = [c*WIDTH +: WIDTH]
//   trig_mask   in   NCHAN*WIDTH per-bit enable (1 = enabled)
//   cfg_mode    in   2*NCHAN per-channel mode: 00 rise, 01 fall, 10 both, 11 level
//   snap_req    in   one-cycle snapshot request
//   rd_sel      in   channel to read
//   rd_data     out  hold register of rd_sel (registered, 0 when rd_sel >= NCHAN)
//   rd_ovf      out  held lost-event count of rd_sel (registered)
//   snap_done   out  one-cycle pulse the cycle after snap_req
//   pending     out  OR of all live accumulator bits
module ok_trigger_capture_bank #(
  parameter int WIDTH = 32,
  parameter int NCHAN = 4,
  parameter int OVF_W = 8,
  parameter int SEL_W = 2
) (
  input  logic                   ti_clk,
  input  logic                   ti_reset,
  input  logic [NCHAN*WIDTH-1:0] ep_trigger,
  input  logic [NCHAN*WIDTH-1:0] trig_mask,
  input  logic [2*NCHAN-1:0]     cfg_mode,
  input  logic                   snap_req,
  input  logic [SEL_W-1:0]       rd_sel,
  output logic [WIDTH-1:0]       rd_data,
  output logic [OVF_W-1:0]       rd_ovf,
  output logic                   snap_done,
  output logic                   pending
);

  localparam logic [OVF_W-1:0] OVF_ONE = OVF_W'(1);
  localparam logic [OVF_W-1:0] OVF_MAX = '1;

  logic [NCHAN*WIDTH-1:0] prev;
  logic [WIDTH-1:0]       accum     [NCHAN];
  logic [WIDTH-1:0]       hold      [NCHAN];
  logic [OVF_W-1:0]       ovf_live  [NCHAN];
  logic [OVF_W-1:0]       ovf_hold  [NCHAN];

  logic [WIDTH-1:0]       ev        [NCHAN];
  logic [WIDTH-1:0]       accum_nxt [NCHAN];
  logic                   lost_any  [NCHAN];
  logic                   any_nxt;
  logic [WIDTH-1:0]       rd_data_nxt;
  logic [OVF_W-1:0]       rd_ovf_nxt;

  always_comb begin
    any_nxt = 1'b0;
    for (int c = 0; c < NCHAN; c++) begin
      case (cfg_mode[2*c +: 2])
        2'b00:   ev[c] = ep_trigger[c*WIDTH +: WIDTH] & ~prev[c*WIDTH +: WIDTH];
        2'b01:   ev[c] = ~ep_trigger[c*WIDTH +: WIDTH] & prev[c*WIDTH +: WIDTH];
        2'b10:   ev[c] = ep_trigger[c*WIDTH +: WIDTH] ^ prev[c*WIDTH +: WIDTH];
        default: ev[c] = ep_trigger[c*WIDTH +: WIDTH];
      endcase
      ev[c] = ev[c] & trig_mask[c*WIDTH +: WIDTH];
      // Level mode re-asserts every cycle by design, so it never counts as lost.
      lost_any[c] = (cfg_mode[2*c +: 2] != 2'b11) && (|(ev[c] & accum[c]));
      // On a snap, same-cycle events open the new window instead of being lost.
      accum_nxt[c] = snap_req ? ev[c] : (accum[c] | ev[c]);
      any_nxt = any_nxt | (|accum_nxt[c]);
    end
  end

  always_comb begin
    rd_data_nxt = '0;
    rd_ovf_nxt  = '0;
    for (int c = 0; c < NCHAN; c++) begin
      if (32'(rd_sel) == 32'(c)) begin
        rd_data_nxt = hold[c];
        rd_ovf_nxt  = ovf_hold[c];
      end
    end
  end

  always_ff @(posedge ti_clk) begin
    if (ti_reset) begin
      prev      <= '0;
      rd_data   <= '0;
      rd_ovf    <= '0;
      snap_done <= 1'b0;
      pending   <= 1'b0;
      for (int c = 0; c < NCHAN; c++) begin
        accum[c]    <= '0;
        hold[c]     <= '0;
        ovf_live[c] <= '0;
        ovf_hold[c] <= '0;
      end
    end else begin
      prev      <= ep_trigger;
      rd_data   <= rd_data_nxt;
      rd_ovf    <= rd_ovf_nxt;
      snap_done <= snap_req;
      pending   <= any_nxt;
      for (int c = 0; c < NCHAN; c++) begin
        accum[c] <= accum_nxt[c];
        if (snap_req) begin
          hold[c]     <= accum[c];
          ovf_hold[c] <= ovf_live[c];
          ovf_live[c] <= '0;
        end else if (lost_any[c] && (ovf_live[c] != OVF_MAX)) begin
          ovf_live[c] <= ovf_live[c] + OVF_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_ok_trigger_capture_bank.sv
// Directed bench for ok_trigger_capture_bank: 32-bit x 4 channels, 8-bit
// lost counters, 3-bit rd_sel so an out-of-range channel can be selected.
module tb_ok_trigger_capture_bank;

  localparam int W = 32;
  localparam int N = 4;
  localparam int O = 8;
  localparam int S = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [N*W-1:0]   trig;
  logic [N*W-1:0]   mask;
  logic [2*N-1:0]   mode;
  logic             snap_req;
  logic [S-1:0]     rd_sel;
  logic [W-1:0]     rd_data;
  logic [O-1:0]     rd_ovf;
  logic             snap_done;
  logic             pending;

  int n_cmp = 0;
  int n_err = 0;

  ok_trigger_capture_bank #(.WIDTH(W), .NCHAN(N), .OVF_W(O), .SEL_W(S)) dut (
    .ti_clk     (clk),
    .ti_reset   (rst),
    .ep_trigger (trig),
    .trig_mask  (mask),
    .cfg_mode   (mode),
    .snap_req   (snap_req),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data),
    .rd_ovf     (rd_ovf),
    .snap_done  (snap_done),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_snap(input string tag);
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    chk({tag, " snap_done hi"}, 32'(snap_done), 32'd1);
    step();
    chk({tag, " snap_done lo"}, 32'(snap_done), 32'd0);
  endtask

  task automatic rd(input int ch, input string tag, input logic [31:0] exp_d, input logic [31:0] exp_o);
    rd_sel = S'(ch);
    step();
    chk({tag, " rd_data"}, rd_data, exp_d);
    chk({tag, " rd_ovf"}, 32'(rd_ovf), exp_o);
  endtask

  initial begin
    trig     = '0;
    trig[0]  = 1'b1;
    mask     = '1;
    mode     = '0;
    snap_req = 1'b0;
    rd_sel   = '0;
    rst      = 1'b1;

    // 1: input high through reset gives one rise event after reset
    step(2);
    chk("rst rd_data", rd_data, 32'h0);
    chk("rst rd_ovf", 32'(rd_ovf), 32'h0);
    chk("rst snap_done", 32'(snap_done), 32'h0);
    chk("rst pending", 32'(pending), 32'h0);
    rst = 1'b0;
    step();
    chk("t1 pending", 32'(pending), 32'h1);
    trig[0] = 1'b0;
    step();
    do_snap("t1");
    rd(0, "t1 ch0", 32'h1, 32'h0);

    // 2: channel 1 falling edge on bit 5
    mode[3:2] = 2'b01;
    trig[W+5] = 1'b1;
    step(3);
    trig[W+5] = 1'b0;
    step(2);
    do_snap("t2");
    rd(1, "t2 ch1", 32'h20, 32'h0);
    rd(0, "t2 ch0", 32'h0, 32'h0);

    // 3: three pulses -> two lost; then 300 pulses saturate
    for (int i = 0; i < 3; i++) begin
      trig[0] = 1'b1; step();
      trig[0] = 1'b0; step();
    end
    do_snap("t3");
    rd(0, "t3 ch0", 32'h1, 32'h2);
    for (int i = 0; i < 300; i++) begin
      trig[0] = 1'b1; step();
      trig[0] = 1'b0; step();
    end
    do_snap("t3s");
    rd(0, "t3s ch0", 32'h1, 32'hFF);

    // 4: edge coincident with snap goes to the next window
    trig[3]  = 1'b1;
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    chk("t4 snap_done hi", 32'(snap_done), 32'h1);
    chk("t4 pending", 32'(pending), 32'h1);
    step();
    chk("t4 snap_done lo", 32'(snap_done), 32'h0);
    rd(0, "t4 first", 32'h0, 32'h0);
    do_snap("t4b");
    rd(0, "t4 second", 32'h8, 32'h0);
    trig[3] = 1'b0;
    // back-to-back snaps: second one holds the single-cycle window of the first
    trig[0]  = 1'b1;
    snap_req = 1'b1;
    step();
    chk("t4 b2b done1", 32'(snap_done), 32'h1);
    step();
    snap_req = 1'b0;
    chk("t4 b2b done2", 32'(snap_done), 32'h1);
    rd(0, "t4 b2b", 32'h1, 32'h0);
    trig[0] = 1'b0;
    step();
    chk("t4 pending clr", 32'(pending), 32'h0);

    // 5: masked bit never accumulates; unmasked it counts
    mode[5:4]   = 2'b10;
    mask[2*W+7] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      trig[2*W+7] = ~trig[2*W+7];
      step();
    end
    chk("t5 pending masked", 32'(pending), 32'h0);
    do_snap("t5");
    rd(2, "t5 masked", 32'h0, 32'h0);
    mask[2*W+7] = 1'b1;
    trig[2*W+7] = 1'b1;
    step();
    chk("t5 pending", 32'(pending), 32'h1);
    do_snap("t5u");
    rd(2, "t5 unmasked", 32'h80, 32'h0);
    trig[2*W+7] = 1'b0;
    step();

    // 6: level mode never counts lost events; out-of-range read; reset discards
    do_snap("t6pre");
    mode[7:6]   = 2'b11;
    trig[3*W+2] = 1'b1;
    step(10);
    trig[3*W+2] = 1'b0;
    step();
    do_snap("t6");
    rd(3, "t6 ch3", 32'h4, 32'h0);
    rd(4, "t6 sel4", 32'h0, 32'h0);
    trig[0] = 1'b1;
    step();
    chk("t6 pending pre", 32'(pending), 32'h1);
    trig[0] = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6 rst rd_data", rd_data, 32'h0);
    step();
    chk("t6 pending post", 32'(pending), 32'h0);
    do_snap("t6r");
    rd(0, "t6 after rst", 32'h0, 32'h0);
    rd(3, "t6 ch3 rst", 32'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
